// File: rtl/game_pkg.sv
// Shared types and constants for the falling-character game datapath.
package game_pkg;

   localparam int ASCII_W = 8;
   localparam int COORD_W = 10;
   localparam int SPEED_W = 3;

   localparam logic [COORD_W-1:0] BOTTOM_DEFAULT = 10'd480;

   // One falling character.
   typedef struct packed {
      logic               valid;
      logic [ASCII_W-1:0] ascii;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [SPEED_W-1:0] speed;
   } slot_t;

   // Scheduler states; OVER is terminal until reset.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_MOVE   = 3'd1,
      ST_MATCH  = 3'd2,
      ST_COMMIT = 3'd3,
      ST_SPAWN  = 3'd4,
      ST_OVER   = 3'd5
   } state_t;

   // Score increment that sticks at 255 instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/slot_table.sv
// Register file of character slots: one write port, a scan read port for
// the scheduler FSM and an independent read port for the renderer.
module slot_table
   import game_pkg::*;
#(
   parameter int SLOTS = 16,
   parameter int IDX_W = $clog2(SLOTS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we_i,
   input  logic [IDX_W-1:0]   wr_idx_i,
   input  slot_t              wr_data_i,
   input  logic [IDX_W-1:0]   scan_idx_i,
   output slot_t              scan_data_o,
   input  logic [IDX_W-1:0]   rd_idx_i,
   output logic               rd_valid_o,
   output logic [ASCII_W-1:0] rd_ascii_o,
   output logic [COORD_W-1:0] rd_x_o,
   output logic [COORD_W-1:0] rd_y_o
);

   slot_t slots_q [SLOTS];

   // Slot storage: cleared by reset, otherwise written one slot per cycle.
   always_ff @(posedge clk) begin
      // NOTE: this storage is deliberately reset -- the game requires every
      // slot to read invalid right after reset, so it cannot map to a RAM.
      if (reset) begin
         for (int i = 0; i < SLOTS; i++) slots_q[i] <= '0;
      end else if (we_i) begin
         slots_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign scan_data_o = slots_q[scan_idx_i];

   assign rd_valid_o = slots_q[rd_idx_i].valid;
   assign rd_ascii_o = slots_q[rd_idx_i].ascii;
   assign rd_x_o     = slots_q[rd_idx_i].x;
   assign rd_y_o     = slots_q[rd_idx_i].y;

endmodule

// File: rtl/char_slot_scheduler.sv
// Serialises spawn, key-hit and frame-move updates to the falling-character
// table, and keeps score and the sticky gameover flag.
module char_slot_scheduler
   import game_pkg::*;
#(
   parameter int                 SLOTS  = 16,
   parameter logic [COORD_W-1:0] BOTTOM = BOTTOM_DEFAULT,
   parameter int                 IDX_W  = $clog2(SLOTS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               spawn_valid,
   output logic               spawn_ready,
   input  logic [ASCII_W-1:0] spawn_ascii,
   input  logic [COORD_W-1:0] spawn_x,
   input  logic [SPEED_W-1:0] spawn_speed,
   input  logic               key_valid,
   input  logic [ASCII_W-1:0] key_ascii,
   input  logic               frame_tick,
   input  logic [IDX_W-1:0]   rd_idx,
   output logic               rd_valid,
   output logic [ASCII_W-1:0] rd_ascii,
   output logic [COORD_W-1:0] rd_x,
   output logic [COORD_W-1:0] rd_y,
   output logic [7:0]         score,
   output logic               gameover,
   output logic               busy,
   output logic               hit,
   output logic               miss,
   output logic               drop
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               pend_tick_q, pend_tick_d;
   logic               pend_key_q, pend_key_d;
   logic [ASCII_W-1:0] key_code_q, key_code_d;
   logic [ASCII_W-1:0] match_key_q, match_key_d;
   logic [ASCII_W-1:0] sp_ascii_q, sp_ascii_d;
   logic [COORD_W-1:0] sp_x_q, sp_x_d;
   logic [SPEED_W-1:0] sp_speed_q, sp_speed_d;
   logic               cand_found_q, cand_found_d;
   logic [IDX_W-1:0]   cand_idx_q, cand_idx_d;
   logic [COORD_W-1:0] cand_y_q, cand_y_d;
   logic [7:0]         score_q, score_d;
   logic               gameover_q, gameover_d;
   logic               hit_q, hit_d;
   logic               miss_q, miss_d;
   logic               drop_q, drop_d;

   logic               tbl_we;
   logic [IDX_W-1:0]   tbl_wr_idx;
   slot_t              tbl_wr_data;
   logic [IDX_W-1:0]   scan_idx;
   slot_t              scan_data;
   logic [COORD_W-1:0] y_new;

   slot_table #(
      .SLOTS (SLOTS),
      .IDX_W (IDX_W)
   ) u_table (
      .clk         (clk),
      .reset       (reset),
      .we_i        (tbl_we),
      .wr_idx_i    (tbl_wr_idx),
      .wr_data_i   (tbl_wr_data),
      .scan_idx_i  (scan_idx),
      .scan_data_o (scan_data),
      .rd_idx_i    (rd_idx),
      .rd_valid_o  (rd_valid),
      .rd_ascii_o  (rd_ascii),
      .rd_x_o      (rd_x),
      .rd_y_o      (rd_y)
   );

   // COMMIT re-reads the winning slot so only its valid bit is cleared.
   assign scan_idx = (state_q == ST_COMMIT) ? cand_idx_q : idx_q;

   // 479 + 7 stays below 1024, so the 10-bit sum cannot wrap.
   assign y_new = scan_data.y + COORD_W'(scan_data.speed);

   // State register and all datapath registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments only,
      // so every register samples the pre-edge values of the others.
      if (reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         pend_tick_q  <= 1'b0;
         pend_key_q   <= 1'b0;
         key_code_q   <= '0;
         match_key_q  <= '0;
         sp_ascii_q   <= '0;
         sp_x_q       <= '0;
         sp_speed_q   <= '0;
         cand_found_q <= 1'b0;
         cand_idx_q   <= '0;
         cand_y_q     <= '0;
         score_q      <= '0;
         gameover_q   <= 1'b0;
         hit_q        <= 1'b0;
         miss_q       <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         pend_tick_q  <= pend_tick_d;
         pend_key_q   <= pend_key_d;
         key_code_q   <= key_code_d;
         match_key_q  <= match_key_d;
         sp_ascii_q   <= sp_ascii_d;
         sp_x_q       <= sp_x_d;
         sp_speed_q   <= sp_speed_d;
         cand_found_q <= cand_found_d;
         cand_idx_q   <= cand_idx_d;
         cand_y_q     <= cand_y_d;
         score_q      <= score_d;
         gameover_q   <= gameover_d;
         hit_q        <= hit_d;
         miss_q       <= miss_d;
         drop_q       <= drop_d;
      end
   end

   // Next-state, table-write and pending-request logic.
   always_comb begin
      // NOTE: every _d and table control gets a default before the case so
      // no branch leaves a signal unassigned and infers a latch.
      state_d      = state_q;
      idx_d        = idx_q;
      pend_tick_d  = pend_tick_q;
      pend_key_d   = pend_key_q;
      key_code_d   = key_code_q;
      match_key_d  = match_key_q;
      sp_ascii_d   = sp_ascii_q;
      sp_x_d       = sp_x_q;
      sp_speed_d   = sp_speed_q;
      cand_found_d = cand_found_q;
      cand_idx_d   = cand_idx_q;
      cand_y_d     = cand_y_q;
      score_d      = score_q;
      gameover_d   = gameover_q;
      hit_d        = 1'b0;
      miss_d       = 1'b0;
      drop_d       = 1'b0;
      tbl_we       = 1'b0;
      tbl_wr_idx   = idx_q;
      tbl_wr_data  = scan_data;

      case (state_q)
         ST_IDLE: begin
            if (pend_tick_q) begin
               state_d     = ST_MOVE;
               pend_tick_d = 1'b0;
               idx_d       = '0;
            end else if (pend_key_q) begin
               state_d      = ST_MATCH;
               pend_key_d   = 1'b0;
               match_key_d  = key_code_q;
               idx_d        = '0;
               cand_found_d = 1'b0;
               cand_idx_d   = '0;
               cand_y_d     = '0;
            end else if (spawn_valid) begin
               state_d    = ST_SPAWN;
               sp_ascii_d = spawn_ascii;
               sp_x_d     = spawn_x;
               sp_speed_d = spawn_speed;
               idx_d      = '0;
            end
         end

         ST_MOVE: begin
            if (scan_data.valid) begin
               tbl_we = 1'b1;
               if (y_new >= BOTTOM) begin
                  tbl_wr_data.valid = 1'b0;
                  gameover_d        = 1'b1;
               end else begin
                  tbl_wr_data.y = y_new;
               end
            end
            if (idx_q == LAST_IDX) begin
               state_d = gameover_d ? ST_OVER : ST_IDLE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end

         ST_MATCH: begin
            // Strict '>' keeps the earlier (lower-index) slot on equal y.
            if (scan_data.valid && scan_data.ascii == match_key_q &&
                (!cand_found_q || scan_data.y > cand_y_q)) begin
               cand_found_d = 1'b1;
               cand_idx_d   = idx_q;
               cand_y_d     = scan_data.y;
            end
            if (idx_q == LAST_IDX) begin
               state_d = ST_COMMIT;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end

         ST_COMMIT: begin
            if (cand_found_q) begin
               tbl_we            = 1'b1;
               tbl_wr_idx        = cand_idx_q;
               tbl_wr_data.valid = 1'b0;
               score_d           = sat_inc8(score_q);
               hit_d             = 1'b1;
            end else begin
               miss_d = 1'b1;
            end
            state_d = ST_IDLE;
         end

         ST_SPAWN: begin
            if (!scan_data.valid) begin
               tbl_we            = 1'b1;
               tbl_wr_data.valid = 1'b1;
               tbl_wr_data.ascii = sp_ascii_q;
               tbl_wr_data.x     = sp_x_q;
               tbl_wr_data.y     = '0;
               tbl_wr_data.speed = sp_speed_q;
               state_d           = ST_IDLE;
            end else if (idx_q == LAST_IDX) begin
               drop_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end

         ST_OVER: begin
            state_d = ST_OVER;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // New pulses override a consumed or older pending request.
      if (frame_tick) pend_tick_d = 1'b1;
      if (key_valid) begin
         pend_key_d = 1'b1;
         key_code_d = key_ascii;
      end
      if (state_q == ST_OVER) begin
         pend_tick_d = 1'b0;
         pend_key_d  = 1'b0;
      end
   end

   // Handshake and status outputs decoded from the current state.
   always_comb begin
      spawn_ready = (state_q == ST_IDLE) && !pend_tick_q && !pend_key_q && !reset;
      busy        = (state_q != ST_IDLE);
   end

   assign score    = score_q;
   assign gameover = gameover_q;
   assign hit      = hit_q;
   assign miss     = miss_q;
   assign drop     = drop_q;

endmodule

// File: tb/tb_char_slot_scheduler.sv
// Directed self-checking bench for char_slot_scheduler (SLOTS=16).
module tb_char_slot_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       spawn_valid;
   logic       spawn_ready;
   logic [7:0] spawn_ascii;
   logic [9:0] spawn_x;
   logic [2:0] spawn_speed;
   logic       key_valid;
   logic [7:0] key_ascii;
   logic       frame_tick;
   logic [3:0] rd_idx;
   logic       rd_valid;
   logic [7:0] rd_ascii;
   logic [9:0] rd_x;
   logic [9:0] rd_y;
   logic [7:0] score;
   logic       gameover;
   logic       busy;
   logic       hit;
   logic       miss;
   logic       drop;

   int   n_checks = 0;
   int   n_errors = 0;
   logic seen_hit, seen_miss, seen_drop, seen_ready;

   char_slot_scheduler #(.SLOTS(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .spawn_valid (spawn_valid),
      .spawn_ready (spawn_ready),
      .spawn_ascii (spawn_ascii),
      .spawn_x     (spawn_x),
      .spawn_speed (spawn_speed),
      .key_valid   (key_valid),
      .key_ascii   (key_ascii),
      .frame_tick  (frame_tick),
      .rd_idx      (rd_idx),
      .rd_valid    (rd_valid),
      .rd_ascii    (rd_ascii),
      .rd_x        (rd_x),
      .rd_y        (rd_y),
      .score       (score),
      .gameover    (gameover),
      .busy        (busy),
      .hit         (hit),
      .miss        (miss),
      .drop        (drop)
   );

   always #5 clk = ~clk;

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_seen();
      seen_hit  = 1'b0;
      seen_miss = 1'b0;
      seen_drop = 1'b0;
   endtask

   task automatic sample_pulses();
      seen_hit  = seen_hit  | hit;
      seen_miss = seen_miss | miss;
      seen_drop = seen_drop | drop;
   endtask

   // Wait until the block has been idle for three consecutive samples.
   task automatic settle();
      int idle_run = 0;
      int n = 0;
      while (idle_run < 3 && n < 500) begin
         @(negedge clk);
         n++;
         sample_pulses();
         if (busy) idle_run = 0;
         else      idle_run++;
      end
      if (idle_run < 3) check("settle_timeout", 32'(idle_run), 3);
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sample_pulses();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_score",       32'(score),       0);
      check("rst_gameover",    32'(gameover),    0);
      check("rst_busy",        32'(busy),        0);
      check("rst_spawn_ready", 32'(spawn_ready), 0);
      check("rst_hit",         32'(hit),         0);
      check("rst_drop",        32'(drop),        0);
      rd_idx = 4'd0;
      #1;
      check("rst_rd_valid", 32'(rd_valid), 0);
      reset = 1'b0;
   endtask

   task automatic spawn(input logic [7:0] a, input logic [9:0] x, input logic [2:0] sp);
      int n = 0;
      clear_seen();
      @(negedge clk);
      spawn_valid = 1'b1;
      spawn_ascii = a;
      spawn_x     = x;
      spawn_speed = sp;
      while (!spawn_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("spawn_ready_timeout", 32'(spawn_ready), 1);
      @(negedge clk);
      spawn_valid = 1'b0;
      settle();
   endtask

   task automatic press(input logic [7:0] a);
      clear_seen();
      @(negedge clk);
      key_valid = 1'b1;
      key_ascii = a;
      @(negedge clk);
      key_valid = 1'b0;
      settle();
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         frame_tick = 1'b1;
         @(negedge clk);
         frame_tick = 1'b0;
         settle();
      end
   endtask

   task automatic check_slot(input string tag, input int idx, input logic v,
                             input logic [7:0] a, input logic [9:0] y);
      rd_idx = 4'(idx);
      #1;
      check({tag, "_valid"}, 32'(rd_valid), 32'(v));
      if (v) begin
         check({tag, "_ascii"}, 32'(rd_ascii), 32'(a));
         check({tag, "_y"},     32'(rd_y),     32'(y));
      end
   endtask

   initial begin
      reset       = 1'b1;
      spawn_valid = 1'b0;
      spawn_ascii = '0;
      spawn_x     = '0;
      spawn_speed = '0;
      key_valid   = 1'b0;
      key_ascii   = '0;
      frame_tick  = 1'b0;
      rd_idx      = '0;
      clear_seen();

      // Three spawns land in slots 0..2 at the top.
      do_reset();
      spawn(8'h41, 10'd40, 3'd2);
      spawn(8'h42, 10'd80, 3'd1);
      spawn(8'h43, 10'd120, 3'd7);
      check_slot("sp_s0", 0, 1'b1, 8'h41, 10'd0);
      check_slot("sp_s1", 1, 1'b1, 8'h42, 10'd0);
      check_slot("sp_s2", 2, 1'b1, 8'h43, 10'd0);
      rd_idx = 4'd1;
      #1;
      check("sp_s1_x", 32'(rd_x), 80);
      check_slot("sp_s3", 3, 1'b0, 8'h00, 10'd0);
      check("sp_score", 32'(score), 0);

      // Ten frames: y = 10*speed.
      tick_n(10);
      check_slot("mv_s0", 0, 1'b1, 8'h41, 10'd20);
      check_slot("mv_s1", 1, 1'b1, 8'h42, 10'd10);
      check_slot("mv_s2", 2, 1'b1, 8'h43, 10'd70);
      check("mv_gameover", 32'(gameover), 0);

      // Build 'A' at slot 3 (y=100) and slot 5 (y=200).
      do_reset();
      spawn(8'h44, 10'd0, 3'd0);
      spawn(8'h44, 10'd0, 3'd0);
      spawn(8'h44, 10'd0, 3'd0);
      spawn(8'h58, 10'd0, 3'd0);
      spawn(8'h44, 10'd0, 3'd0);
      spawn(8'h41, 10'd200, 3'd5);
      tick_n(20);
      check_slot("a5_y100", 5, 1'b1, 8'h41, 10'd100);
      press(8'h58);
      check("x_hit", 32'(seen_hit), 1);
      check("x_score", 32'(score), 1);
      check_slot("x_s3_cleared", 3, 1'b0, 8'h00, 10'd0);
      spawn(8'h41, 10'd300, 3'd5);
      check_slot("a3_new", 3, 1'b1, 8'h41, 10'd0);
      tick_n(20);
      check_slot("a3_y100", 3, 1'b1, 8'h41, 10'd100);
      check_slot("a5_y200", 5, 1'b1, 8'h41, 10'd200);
      press(8'h41);
      check("a_hit", 32'(seen_hit), 1);
      check("a_miss", 32'(seen_miss), 0);
      check("a_score", 32'(score), 2);
      check_slot("a_s5_cleared", 5, 1'b0, 8'h00, 10'd0);
      check_slot("a_s3_kept", 3, 1'b1, 8'h41, 10'd100);
      press(8'h5A);
      check("z_miss", 32'(seen_miss), 1);
      check("z_hit", 32'(seen_hit), 0);
      check("z_score", 32'(score), 2);

      // Fill the table (slots 5..15), then one spawn too many.
      for (int i = 0; i < 11; i++) spawn(8'h46, 10'd500, 3'd0);
      check("fill_no_drop", 32'(seen_drop), 0);
      spawn(8'h47, 10'd600, 3'd0);
      check("full_drop", 32'(seen_drop), 1);
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i);
         #1;
         check($sformatf("full_valid_%0d", i), 32'(rd_valid), 1);
      end
      check_slot("full_s15", 15, 1'b1, 8'h46, 10'd0);
      check_slot("full_s3", 3, 1'b1, 8'h41, 10'd100);

      // Landing exactly at BOTTOM ends the game.
      do_reset();
      spawn(8'h48, 10'd10, 3'd4);
      spawn(8'h4A, 10'd20, 3'd0);
      tick_n(119);
      check_slot("go_s0_476", 0, 1'b1, 8'h48, 10'd476);
      check("go_before", 32'(gameover), 0);
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      wait_cycles(40);
      check("go_flag", 32'(gameover), 1);
      check("go_busy", 32'(busy), 1);
      check_slot("go_s0_cleared", 0, 1'b0, 8'h00, 10'd0);
      check_slot("go_s1_frozen", 1, 1'b1, 8'h4A, 10'd0);
      seen_ready = 1'b0;
      spawn_valid = 1'b1;
      spawn_ascii = 8'h4B;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         seen_ready = seen_ready | spawn_ready;
      end
      spawn_valid = 1'b0;
      check("go_spawn_ready", 32'(seen_ready), 0);
      clear_seen();
      @(negedge clk);
      key_valid  = 1'b1;
      key_ascii  = 8'h4A;
      frame_tick = 1'b1;
      @(negedge clk);
      key_valid  = 1'b0;
      frame_tick = 1'b0;
      wait_cycles(40);
      check("go_key_ignored_hit", 32'(seen_hit), 0);
      check("go_key_ignored_miss", 32'(seen_miss), 0);
      check("go_score", 32'(score), 0);
      check_slot("go_s1_still", 1, 1'b1, 8'h4A, 10'd0);
      do_reset();
      check_slot("go_rst_s1", 1, 1'b0, 8'h00, 10'd0);

      // Drive score to 255 with repeated spawn + hit.
      for (int i = 0; i < 255; i++) begin
         spawn(8'h4B, 10'd0, 3'd0);
         press(8'h4B);
      end
      check("sat_score_255", 32'(score), 255);
      check_slot("sat_s0_empty", 0, 1'b0, 8'h00, 10'd0);

      // Same-cycle tick and key: MOVE first makes slot 1 (sp 3) the highest.
      spawn(8'h4C, 10'd0, 3'd0);
      spawn(8'h4C, 10'd0, 3'd3);
      clear_seen();
      @(negedge clk);
      frame_tick = 1'b1;
      key_valid  = 1'b1;
      key_ascii  = 8'h4C;
      @(negedge clk);
      frame_tick = 1'b0;
      key_valid  = 1'b0;
      settle();
      check("both_hit", 32'(seen_hit), 1);
      check("both_score_sat", 32'(score), 255);
      check_slot("both_s0_kept", 0, 1'b1, 8'h4C, 10'd0);
      check_slot("both_s1_cleared", 1, 1'b0, 8'h00, 10'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
